lcd_message_sequencer: RTL and testbench

- Sole Avalon-MM master for the character-LCD controller slave (address 0 = instruction register, 1 = data register).
- Replaces the per-effect text generators and the output mux that selects between them.
- Draws a 16-character effect name on line 1 and, optionally, a 3-digit level on line 2, from an internal string ROM.
- Re-draws automatically whenever the effect selection or the level changes.

---
 rtl/lcd_message_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_lcd_message_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_message_sequencer.sv
// Avalon-MM master that draws an effect name (line 1) and an optional 3-digit level
// (line 2, LCD_LEVEL_LINE_EN) on a character LCD and redraws whenever the inputs change.
//
// state  | meaning
// IDLE   | waiting for pending; latches the snapshot on exit
// CLEAR  | write instruction 0x01 (clear display)
// WAIT   | clear-display settle time, down-counter to zero
// HOME1  | write instruction 0x80 (cursor to line 1)
// LINE1  | write 16 name characters
// HOME2  | write instruction 0xC0 (cursor to line 2)
// LINE2  | write "LEVEL: ddd" padded to 16
// FINISH | drop busy, pulse done
module lcd_message_sequencer #(
  parameter int CLEAR_WAIT_CYCLES = 100000,
  parameter int LINE_LEN          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] effect_sel,
  input  logic [7:0] level,
  output logic       address,
  output logic       chipselect,
  output logic       write,
  output logic [7:0] writedata,
  input  logic       waitrequest,
  output logic       busy,
  output logic       done
);

  localparam int         WAIT_W   = $clog2(CLEAR_WAIT_CYCLES + 1);
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  localparam logic [127:0] NAME_COLOUR = "COLOUR          ";
  localparam logic [127:0] NAME_BLUR   = "BLUR            ";
  localparam logic [127:0] NAME_BRIGHT = "BRIGHTNESS      ";
  localparam logic [127:0] NAME_EDGE   = "EDGE DETECT     ";

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_HOME1, S_LINE1, S_HOME2, S_LINE2, S_FINISH
  } state_t;

  state_t              r_state;
  logic                r_write;
  logic                r_address;
  logic [7:0]          r_writedata;
  logic                r_busy;
  logic                r_done;
  logic                r_pending;
  logic [1:0]          r_prev_sel;
  logic [1:0]          r_snap_sel;
  logic [3:0]          r_char_idx;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                w_change;
  logic                w_accept;
  logic                w_write_state;
  logic                w_req_addr;
  logic [7:0]          w_req_data;

  function automatic logic [7:0] name_char(input logic [1:0] sel, input logic [3:0] idx);
    logic [127:0] s;
    s = NAME_COLOUR;
    case (sel)
      2'd0: s = NAME_COLOUR;
      2'd1: s = NAME_BLUR;
      2'd2: s = NAME_BRIGHT;
      2'd3: s = NAME_EDGE;
      default: s = NAME_COLOUR;
    endcase
    return s[8*(15-int'(idx)) +: 8];
  endfunction

`ifdef LCD_LEVEL_LINE_EN
  localparam logic [55:0] LEVEL_LABEL = "LEVEL: ";

  logic [7:0]  r_prev_level;
  logic [7:0]  r_snap_level;
  logic [11:0] r_bcd;

  // Double-dabble; result is registered, so it settles long before HOME2.
  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [19:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = {sh[18:0], 1'b0};
    end
    return sh[19:8];
  endfunction

  function automatic logic [7:0] line2_char(input logic [11:0] bcd, input logic [3:0] idx);
    logic [7:0] c;
    c = 8'h20;
    if (idx < 4'd7)       c = LEVEL_LABEL[8*(6-int'(idx)) +: 8];
    else if (idx == 4'd7) c = {4'h3, bcd[11:8]};
    else if (idx == 4'd8) c = {4'h3, bcd[7:4]};
    else if (idx == 4'd9) c = {4'h3, bcd[3:0]};
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_level <= 8'h00;
      r_snap_level <= 8'h00;
      r_bcd        <= 12'h000;
    end else begin
      r_prev_level <= level;
      r_bcd        <= to_bcd(r_snap_level);
      if (r_state == S_IDLE && r_pending) r_snap_level <= level;
    end
  end
`else
  logic w_unused_level;
  assign w_unused_level = ^level;
`endif

  always_comb begin
    w_change = (effect_sel != r_prev_sel);
`ifdef LCD_LEVEL_LINE_EN
    w_change = w_change | (level != r_prev_level);
`endif
  end

  assign w_accept      = r_write & ~waitrequest;
  assign w_write_state = r_state inside {S_CLEAR, S_HOME1, S_LINE1, S_HOME2, S_LINE2};

  always_comb begin
    w_req_addr = 1'b0;
    w_req_data = 8'h00;
    case (r_state)
      S_CLEAR: w_req_data = 8'h01;
      S_HOME1: w_req_data = 8'h80;
      S_LINE1: begin
        w_req_addr = 1'b1;
        w_req_data = name_char(r_snap_sel, r_char_idx);
      end
`ifdef LCD_LEVEL_LINE_EN
      S_HOME2: w_req_data = 8'hC0;
      S_LINE2: begin
        w_req_addr = 1'b1;
        w_req_data = line2_char(r_bcd, r_char_idx);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_address   <= 1'b0;
      r_writedata <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pending   <= 1'b1;
      r_prev_sel  <= 2'b00;
      r_snap_sel  <= 2'b00;
      r_char_idx  <= 4'd0;
      r_wait_cnt  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_prev_sel <= effect_sel;

      // Leaving IDLE samples the live inputs, so a change seen in that same cycle is already covered.
      if (r_state == S_IDLE && r_pending) r_pending <= 1'b0;
      else if (w_change)                  r_pending <= 1'b1;

      if (w_write_state && !r_write) begin
        r_write     <= 1'b1;
        r_address   <= w_req_addr;
        r_writedata <= w_req_data;
      end else if (w_accept) begin
        r_write <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (r_pending) begin
          r_snap_sel <= effect_sel;
          r_busy     <= 1'b1;
          r_state    <= S_CLEAR;
        end
        S_CLEAR: if (w_accept) begin
          r_wait_cnt <= WAIT_W'(CLEAR_WAIT_CYCLES - 1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) r_state <= S_HOME1;
          else                  r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        S_HOME1: if (w_accept) begin
          r_char_idx <= 4'd0;
          r_state    <= S_LINE1;
        end
        S_LINE1: if (w_accept) begin
          r_char_idx <= r_char_idx + 4'd1;
          if (r_char_idx == LAST_IDX) begin
`ifdef LCD_LEVEL_LINE_EN
            r_state <= S_HOME2;
`else
            r_state <= S_FINISH;
`endif
          end
        end
`ifdef LCD_LEVEL_LINE_EN
        S_HOME2: if (w_accept) begin
          r_char_idx <= 4'd0;
          r_state    <= S_LINE2;
        end
        S_LINE2: if (w_accept) begin
          r_char_idx <= r_char_idx + 4'd1;
          if (r_char_idx == LAST_IDX) r_state <= S_FINISH;
        end
`endif
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign address    = r_address;
  assign chipselect = r_write;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_lcd_message_sequencer.sv
// Scoreboard bench for lcd_message_sequencer: stimulus pushes expected LCD writes,
// a negedge monitor pops and compares every accepted Avalon write.
module tb_lcd_message_sequencer;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] effect_sel;
  logic [7:0] level;
  logic       address, chipselect, write, waitrequest, busy, done;
  logic [7:0] writedata;

  always #5 clk = ~clk;

  lcd_message_sequencer #(.CLEAR_WAIT_CYCLES(CW), .LINE_LEN(16)) dut (
    .clk(clk), .reset_n(reset_n), .effect_sel(effect_sel), .level(level),
    .address(address), .chipselect(chipselect), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .busy(busy), .done(done)
  );

  logic [8:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, data_acc = 0, stall_cycles = 0, c0_cnt = 0;
  logic was_stalled = 1'b0, prev_done = 1'b0;
  logic [8:0] held;
  string names[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      was_stalled = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (was_stalled) begin
        chk("stall_write_held", write, 1);
        chk("stall_addr_data_held", {address, writedata}, held);
      end
      if (write) begin
        if (waitrequest) begin
          was_stalled = 1'b1;
          held = {address, writedata};
          stall_cycles++;
        end else begin
          was_stalled = 1'b0;
          chk("chipselect_eq_write", chipselect, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr=%0d data='h%0h, expected no write", address, writedata);
          end else begin
            chk("write_seq", {address, writedata}, exp_q.pop_front());
          end
          if (address) data_acc++;
          if (!address && writedata == 8'hC0) c0_cnt++;
        end
      end else begin
        was_stalled = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", prev_done, 0);
        chk("busy_low_at_done", busy, 0);
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int sel, input int lvl);
    string s;
    string lbl;
    logic [7:0] ch;
    s = names[sel];
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) begin
      ch = (i < s.len()) ? s[i] : 8'h20;
      exp_q.push_back({1'b1, ch});
    end
`ifdef LCD_LEVEL_LINE_EN
    lbl = "LEVEL: ";
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b1, lbl[i]});
    exp_q.push_back({1'b1, 8'(8'h30 + lvl / 100)});
    exp_q.push_back({1'b1, 8'(8'h30 + (lvl / 10) % 10)});
    exp_q.push_back({1'b1, 8'(8'h30 + lvl % 10)});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, 8'h20});
`else
    lbl = "";
    if (lvl < 0) $display("negative level %0d %s", lvl, lbl);
`endif
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt >= n) break;
      tick();
    end
    chk("done_reached", done_cnt >= n, 1);
  endtask

  task automatic wait_acc(input int n, input bit need_wr);
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (data_acc >= n && (!need_wr || write)) break;
    end
    chk("data_writes_reached", data_acc >= n, 1);
  endtask

  int base, dn;

  initial begin
    names[0] = "COLOUR"; names[1] = "BLUR"; names[2] = "BRIGHTNESS"; names[3] = "EDGE DETECT";
    reset_n = 1'b0; effect_sel = 2'b00; level = 8'd0; waitrequest = 1'b0;
    repeat (3) tick();
    chk("rst_write", write, 0);
    chk("rst_chipselect", chipselect, 0);
    chk("rst_address", address, 0);
    chk("rst_writedata", writedata, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // power-up draw
    push_seq(0, 0);
    reset_n = 1'b1;
    tick();
    chk("powerup_busy", busy, 1);
    wait_done(1);
    tick();
    chk("idle_busy_low", busy, 0);
    chk("queue_empty_1", exp_q.size(), 0);

    // effect change while idle
    effect_sel = 2'b11; level = 8'd42;
    push_seq(3, 42);
    wait_done(2);
    chk("queue_empty_2", exp_q.size(), 0);

    // 7-cycle stall on the 3rd data write
    base = data_acc; stall_cycles = 0;
    effect_sel = 2'b01;
    push_seq(1, 42);
    wait_acc(base + 2, 1);
    chk("stall_target_is_data", address, 1);
    waitrequest = 1'b1;
    repeat (7) tick();
    waitrequest = 1'b0;
    wait_done(3);
    chk("stall_cycles", stall_cycles, 7);
    chk("queue_empty_3", exp_q.size(), 0);

`ifdef LCD_LEVEL_LINE_EN
    // level changes mid-sequence give one extra redraw with the last value
    base = data_acc;
    level = 8'd5;
    push_seq(1, 5);
    wait_acc(base + 2, 0);
    level = 8'd200;
    repeat (3) tick();
    level = 8'd255;
    push_seq(1, 255);
    wait_done(5);
    repeat (60) tick();
    chk("single_redraw_done_cnt", done_cnt, 5);
    chk("idle_after_redraw", busy, 0);
    chk("queue_empty_4", exp_q.size(), 0);
`else
    // level is ignored: only the effect change draws
    base = data_acc;
    effect_sel = 2'b10;
    push_seq(2, 0);
    wait_acc(base + 2, 0);
    level = 8'd200;
    repeat (3) tick();
    level = 8'd255;
    wait_done(4);
    repeat (60) tick();
    chk("level_ignored_done_cnt", done_cnt, 4);
    chk("idle_after_draw", busy, 0);
    chk("no_line2_cmd", c0_cnt, 0);
    chk("queue_empty_4", exp_q.size(), 0);
`endif

    // async reset in the middle of LINE1 with a write outstanding
    dn = done_cnt;
    base = data_acc;
    effect_sel = 2'b00;
    push_seq(0, int'(level));
    wait_acc(base + 4, 1);
    chk("pre_reset_write_high", write, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_write", write, 0);
    chk("async_rst_chipselect", chipselect, 0);
    chk("async_rst_address", address, 0);
    chk("async_rst_writedata", writedata, 8'h00);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) tick();
    push_seq(0, int'(level));
    reset_n = 1'b1;
    wait_done(dn + 1);
    repeat (60) tick();
    chk("restart_done_cnt", done_cnt, dn + 1);
    chk("queue_empty_5", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
